// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/LSU arbiter for a shared single-port memory with owner-tagged read return.
// Optional IF starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int RD_LAT     = 1,
   parameter int MAX_STARVE = 4
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_if_req,
   input  logic [AW-1:0]   i_if_addr,
   output logic            o_if_gnt,
   output logic            o_if_rvalid,
   output logic [DW-1:0]   o_if_rdata,
   input  logic            i_ls_req,
   input  logic            i_ls_we,
   input  logic [AW-1:0]   i_ls_addr,
   input  logic [DW-1:0]   i_ls_wdata,
   input  logic [DW/8-1:0] i_ls_bmask,
   output logic            o_ls_gnt,
   output logic            o_ls_rvalid,
   output logic [DW-1:0]   o_ls_rdata,
   output logic            o_mem_en,
   output logic            o_mem_we,
   output logic [AW-1:0]   o_mem_addr,
   output logic [DW-1:0]   o_mem_wdata,
   output logic [DW/8-1:0] o_mem_bmask,
   input  logic [DW-1:0]   i_mem_rdata
);

   localparam int BW = DW / 8;

   generate
      if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
         $error("mem_port_arbiter: RD_LAT must be in 1..4");
      end
      if (DW % 8 != 0) begin : g_bad_dw
         $error("mem_port_arbiter: DW must be a multiple of 8");
      end
      if (MAX_STARVE < 1 || MAX_STARVE > 7) begin : g_bad_starve
         $error("mem_port_arbiter: MAX_STARVE must fit the 3-bit starve counter (1..7)");
      end
   endgenerate

   logic              if_gnt;
   logic              ls_gnt;
   logic              force_if;
   logic [AW-1:0]     addr_q, addr_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic [BW-1:0]     bmask_q, bmask_d;
   logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
   logic [RD_LAT-1:0] tag_own_q, tag_own_d;
   logic              if_rvalid_q, if_rvalid_d;
   logic              ls_rvalid_q, ls_rvalid_d;
   logic [DW-1:0]     if_rdata_q, if_rdata_d;
   logic [DW-1:0]     ls_rdata_q, ls_rdata_d;

`ifdef MEM_ARB_STARVE_GUARD_EN
   logic [2:0] starve_q, starve_d;

   assign force_if = i_if_req && (starve_q == 3'(MAX_STARVE));

   always_comb begin
      starve_d = starve_q;
      if (!i_if_req || if_gnt) begin
         starve_d = 3'd0;
      end else if (ls_gnt && starve_q != 3'd7) begin
         starve_d = starve_q + 3'd1;
      end
   end
`else
   assign force_if = 1'b0;
`endif

   // Grants are gated by reset so every output reads 0 while reset is held.
   always_comb begin
      ls_gnt = !i_reset && i_ls_req && !force_if;
      if_gnt = !i_reset && i_if_req && !ls_gnt;
   end

   always_comb begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      bmask_d = bmask_q;
      if (ls_gnt) begin
         addr_d  = i_ls_addr;
         wdata_d = i_ls_wdata;
         bmask_d = i_ls_bmask;
      end else if (if_gnt) begin
         addr_d  = i_if_addr;
         wdata_d = '0;
         bmask_d = '1;
      end
   end

   // Tag stage 0 lines up with the memory's first output cycle; the tail lines up with i_mem_rdata.
   always_comb begin
      tag_vld_d    = '0;
      tag_own_d    = '0;
      tag_vld_d[0] = if_gnt || (ls_gnt && !i_ls_we);
      tag_own_d[0] = ls_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_own_d[i] = tag_own_q[i-1];
      end
   end

   always_comb begin
      if_rvalid_d = tag_vld_q[RD_LAT-1] && !tag_own_q[RD_LAT-1];
      ls_rvalid_d = tag_vld_q[RD_LAT-1] &&  tag_own_q[RD_LAT-1];
      if_rdata_d  = if_rvalid_d ? i_mem_rdata : if_rdata_q;
      ls_rdata_d  = ls_rvalid_d ? i_mem_rdata : ls_rdata_q;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         addr_q      <= '0;
         wdata_q     <= '0;
         bmask_q     <= '0;
         tag_vld_q   <= '0;
         tag_own_q   <= '0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         ls_rdata_q  <= '0;
`ifdef MEM_ARB_STARVE_GUARD_EN
         starve_q    <= 3'd0;
`endif
      end else begin
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         bmask_q     <= bmask_d;
         tag_vld_q   <= tag_vld_d;
         tag_own_q   <= tag_own_d;
         if_rvalid_q <= if_rvalid_d;
         ls_rvalid_q <= ls_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         ls_rdata_q  <= ls_rdata_d;
`ifdef MEM_ARB_STARVE_GUARD_EN
         starve_q    <= starve_d;
`endif
      end
   end

   assign o_if_gnt    = if_gnt;
   assign o_ls_gnt    = ls_gnt;
   assign o_mem_en    = if_gnt || ls_gnt;
   assign o_mem_we    = ls_gnt && i_ls_we;
   assign o_mem_addr  = addr_d;
   assign o_mem_wdata = wdata_d;
   assign o_mem_bmask = bmask_d;
   assign o_if_rvalid = if_rvalid_q;
   assign o_ls_rvalid = ls_rvalid_q;
   assign o_if_rdata  = if_rdata_q;
   assign o_ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - Directed vector bench for mem_port_arbiter at RD_LAT=1 and RD_LAT=3.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        ls_req;
   logic        ls_we;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic [3:0]  ls_bmask;

   logic        d1_if_gnt, d1_if_rvalid, d1_ls_gnt, d1_ls_rvalid, d1_mem_en, d1_mem_we;
   logic [31:0] d1_if_rdata, d1_ls_rdata, d1_mem_addr, d1_mem_wdata;
   logic [3:0]  d1_mem_bmask;
   logic        d3_if_gnt, d3_if_rvalid, d3_ls_gnt, d3_ls_rvalid, d3_mem_en, d3_mem_we;
   logic [31:0] d3_if_rdata, d3_ls_rdata, d3_mem_addr, d3_mem_wdata;
   logic [3:0]  d3_mem_bmask;

   logic [31:0] mem [0:255];
   logic [31:0] p1;
   logic [31:0] p3 [0:2];
   logic        load_mem;

   int n_pass;
   int n_total;

   mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .MAX_STARVE(4)) u_dut1 (
      .i_clk(clk), .i_reset(rst),
      .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(d1_if_gnt),
      .o_if_rvalid(d1_if_rvalid), .o_if_rdata(d1_if_rdata),
      .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
      .i_ls_bmask(ls_bmask), .o_ls_gnt(d1_ls_gnt), .o_ls_rvalid(d1_ls_rvalid),
      .o_ls_rdata(d1_ls_rdata), .o_mem_en(d1_mem_en), .o_mem_we(d1_mem_we),
      .o_mem_addr(d1_mem_addr), .o_mem_wdata(d1_mem_wdata), .o_mem_bmask(d1_mem_bmask),
      .i_mem_rdata(p1)
   );

   mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .MAX_STARVE(4)) u_dut3 (
      .i_clk(clk), .i_reset(rst),
      .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(d3_if_gnt),
      .o_if_rvalid(d3_if_rvalid), .o_if_rdata(d3_if_rdata),
      .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
      .i_ls_bmask(ls_bmask), .o_ls_gnt(d3_ls_gnt), .o_ls_rvalid(d3_ls_rvalid),
      .o_ls_rdata(d3_ls_rdata), .o_mem_en(d3_mem_en), .o_mem_we(d3_mem_we),
      .o_mem_addr(d3_mem_addr), .o_mem_wdata(d3_mem_wdata), .o_mem_bmask(d3_mem_bmask),
      .i_mem_rdata(p3[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(int i);
      case (i)
         0:       return 32'hA0A0_A0A0;
         1:       return 32'hB1B1_B1B1;
         4:       return 32'hDEAD_BEEF;
         8:       return 32'h2020_2020;
         12:      return 32'h3030_3030;
         16:      return 32'hFFFF_FFFF;
         default: return 32'(i);
      endcase
   endfunction

   function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] m);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) begin
         if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
      end
      return r;
   endfunction

   // Shared memory model; both DUTs see identical requests, so one write port suffices.
   always @(posedge clk) begin
      if (load_mem) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      end else if (d1_mem_en && d1_mem_we) begin
         mem[d1_mem_addr[9:2]] <= merge(mem[d1_mem_addr[9:2]], d1_mem_wdata, d1_mem_bmask);
      end
      p1    <= mem[d1_mem_addr[9:2]];
      p3[0] <= mem[d3_mem_addr[9:2]];
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic ir, input logic [31:0] ia, input logic lr, input logic lw,
                        input logic [31:0] la, input logic [31:0] ld, input logic [3:0] lm);
      if_req   = ir;
      if_addr  = ia;
      ls_req   = lr;
      ls_we    = lw;
      ls_addr  = la;
      ls_wdata = ld;
      ls_bmask = lm;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_dut1_outputs_or"}, {31'b0, |{d1_if_gnt, d1_if_rvalid, d1_if_rdata, d1_ls_gnt,
            d1_ls_rvalid, d1_ls_rdata, d1_mem_en, d1_mem_we, d1_mem_addr, d1_mem_wdata,
            d1_mem_bmask}}, 32'd0);
      check({tag, "_dut3_outputs_or"}, {31'b0, |{d3_if_gnt, d3_if_rvalid, d3_if_rdata, d3_ls_gnt,
            d3_ls_rvalid, d3_ls_rdata, d3_mem_en, d3_mem_we, d3_mem_addr, d3_mem_wdata,
            d3_mem_bmask}}, 32'd0);
   endtask

   typedef struct {
      logic        if_req;
      logic [31:0] if_addr;
      logic        ls_req;
      logic        ls_we;
      logic [31:0] ls_addr;
      logic [31:0] ls_wdata;
      logic [3:0]  ls_bmask;
      logic        e_if_gnt;
      logic        e_ls_gnt;
      logic        e_en;
      logic        e_we;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic [3:0]  e_bmask;
      logic        e_if_rv;
      logic        e_ls_rv;
      logic [31:0] e_if_rd;
      logic [31:0] e_ls_rd;
   } vec_t;

   vec_t tbl [9];

   logic [31:0] seq_addr [6];
   logic [31:0] seq_data [6];
   logic [31:0] h_if1, h_ls1, h_if3, h_ls3;
   logic        exp_if_gnt;

   initial begin
      n_pass   = 0;
      n_total  = 0;
      load_mem = 1'b1;
      rst      = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);

      //            ir  if_addr     lr lw ls_addr     ls_wdata      bm    ig lg en we e_addr      e_wdata       e_bm  irv lrv e_if_rd        e_ls_rd
      tbl[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0,         4'hF, 1'b0, 1'b0, 32'h0,          32'h0};
      tbl[1] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,         4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0,         4'hF, 1'b0, 1'b0, 32'h0,          32'h0};
      tbl[2] = '{1'b1, 32'h30, 1'b1, 1'b0, 32'h20, 32'h0,         4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0,         4'hF, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0};
      tbl[3] = '{1'b1, 32'h30, 1'b0, 1'b0, 32'h0,  32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h30, 32'h0,         4'hF, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0};
      tbl[4] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h40, 32'h1234_5678, 4'h3, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h1234_5678, 4'h3, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h2020_2020};
      tbl[5] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,         4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h1234_5678, 4'h3, 1'b1, 1'b0, 32'h3030_3030, 32'h2020_2020};
      tbl[6] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h40, 32'h0,         4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0,         4'hF, 1'b0, 1'b0, 32'h3030_3030, 32'h2020_2020};
      tbl[7] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,         4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0,         4'hF, 1'b0, 1'b0, 32'h3030_3030, 32'h2020_2020};
      tbl[8] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,         4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0,         4'hF, 1'b0, 1'b1, 32'h3030_3030, 32'hFFFF_5678};

      seq_addr = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h00, 32'h04};
      seq_data = '{32'hDEAD_BEEF, 32'h2020_2020, 32'h3030_3030, 32'hFFFF_5678,
                   32'hA0A0_A0A0, 32'hB1B1_B1B1};

      repeat (2) @(posedge clk);
      #1;
      drive(1, 32'h10, 1, 1, 32'h20, 32'h5555_5555, 4'hF);
      #2;
      check_all_zero("reset_held_with_req");
      next_cycle();
      load_mem = 1'b0;
      rst      = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      #2;
      check_all_zero("after_reset_idle");
      next_cycle();

      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].if_req, tbl[i].if_addr, tbl[i].ls_req, tbl[i].ls_we,
               tbl[i].ls_addr, tbl[i].ls_wdata, tbl[i].ls_bmask);
         #2;
         check($sformatf("r%0d_if_gnt", i),    {31'b0, d1_if_gnt},    {31'b0, tbl[i].e_if_gnt});
         check($sformatf("r%0d_ls_gnt", i),    {31'b0, d1_ls_gnt},    {31'b0, tbl[i].e_ls_gnt});
         check($sformatf("r%0d_mem_en", i),    {31'b0, d1_mem_en},    {31'b0, tbl[i].e_en});
         check($sformatf("r%0d_mem_we", i),    {31'b0, d1_mem_we},    {31'b0, tbl[i].e_we});
         check($sformatf("r%0d_mem_addr", i),  d1_mem_addr,           tbl[i].e_addr);
         check($sformatf("r%0d_mem_wdata", i), d1_mem_wdata,          tbl[i].e_wdata);
         check($sformatf("r%0d_mem_bmask", i), {28'b0, d1_mem_bmask}, {28'b0, tbl[i].e_bmask});
         check($sformatf("r%0d_if_rvalid", i), {31'b0, d1_if_rvalid}, {31'b0, tbl[i].e_if_rv});
         check($sformatf("r%0d_ls_rvalid", i), {31'b0, d1_ls_rvalid}, {31'b0, tbl[i].e_ls_rv});
         check($sformatf("r%0d_if_rdata", i),  d1_if_rdata,           tbl[i].e_if_rd);
         check($sformatf("r%0d_ls_rdata", i),  d1_ls_rdata,           tbl[i].e_ls_rd);
         next_cycle();
      end

      // Both requesters held high: with the guard, every fifth cycle belongs to IF.
      for (int c = 0; c < 10; c++) begin
         drive(1, 32'h10, 1, 0, 32'h20, 32'h0, 4'hF);
         #2;
`ifdef MEM_ARB_STARVE_GUARD_EN
         exp_if_gnt = (c % 5 == 4);
`else
         exp_if_gnt = 1'b0;
`endif
         check($sformatf("starve_c%0d_if_gnt", c), {31'b0, d1_if_gnt}, {31'b0, exp_if_gnt});
         check($sformatf("starve_c%0d_ls_gnt", c), {31'b0, d1_ls_gnt}, {31'b0, !exp_if_gnt});
         check($sformatf("starve_c%0d_mem_addr", c), d1_mem_addr, exp_if_gnt ? 32'h10 : 32'h20);
         next_cycle();
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (6) next_cycle();

      // Reset pulse with an IF read and an LSU read still in flight.
      drive(1, 32'h10, 0, 0, 0, 0, 0);
      next_cycle();
      drive(0, 0, 1, 0, 32'h20, 0, 4'hF);
      next_cycle();
      rst = 1'b1;
      drive(1, 32'h30, 1, 0, 32'h40, 0, 4'hF);
      #2;
      check_all_zero("mid_reset");
      next_cycle();
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 8; c++) begin
         #2;
         check($sformatf("post_rst_c%0d_d1_if_rv", c), {31'b0, d1_if_rvalid}, 32'd0);
         check($sformatf("post_rst_c%0d_d1_ls_rv", c), {31'b0, d1_ls_rvalid}, 32'd0);
         check($sformatf("post_rst_c%0d_d3_if_rv", c), {31'b0, d3_if_rvalid}, 32'd0);
         check($sformatf("post_rst_c%0d_d3_ls_rv", c), {31'b0, d3_ls_rvalid}, 32'd0);
         next_cycle();
      end

      // Alternating IF/LSU reads: response at grant + RD_LAT + 1, rdata held otherwise.
      h_if1 = '0;
      h_ls1 = '0;
      h_if3 = '0;
      h_ls3 = '0;
      for (int c = 0; c < 12; c++) begin
         int k1, k3;
         logic e_if1, e_ls1, e_if3, e_ls3;
         if (c < 6) begin
            if (c % 2 == 0) drive(1, seq_addr[c], 0, 0, 0, 0, 0);
            else            drive(0, 0, 1, 0, seq_addr[c], 0, 4'hF);
         end else begin
            drive(0, 0, 0, 0, 0, 0, 0);
         end
         #2;
         k1 = c - 2;
         k3 = c - 4;
         e_if1 = (k1 >= 0) && (k1 < 6) && (k1 % 2 == 0);
         e_ls1 = (k1 >= 0) && (k1 < 6) && (k1 % 2 == 1);
         e_if3 = (k3 >= 0) && (k3 < 6) && (k3 % 2 == 0);
         e_ls3 = (k3 >= 0) && (k3 < 6) && (k3 % 2 == 1);
         if (e_if1) h_if1 = seq_data[k1];
         if (e_ls1) h_ls1 = seq_data[k1];
         if (e_if3) h_if3 = seq_data[k3];
         if (e_ls3) h_ls3 = seq_data[k3];
         check($sformatf("lat1_c%0d_if_rv", c), {31'b0, d1_if_rvalid}, {31'b0, e_if1});
         check($sformatf("lat1_c%0d_ls_rv", c), {31'b0, d1_ls_rvalid}, {31'b0, e_ls1});
         check($sformatf("lat1_c%0d_if_rd", c), d1_if_rdata, h_if1);
         check($sformatf("lat1_c%0d_ls_rd", c), d1_ls_rdata, h_ls1);
         check($sformatf("lat3_c%0d_if_rv", c), {31'b0, d3_if_rvalid}, {31'b0, e_if3});
         check($sformatf("lat3_c%0d_ls_rv", c), {31'b0, d3_ls_rvalid}, {31'b0, e_ls3});
         check($sformatf("lat3_c%0d_if_rd", c), d3_if_rdata, h_if3);
         check($sformatf("lat3_c%0d_ls_rd", c), d3_ls_rdata, h_ls3);
         next_cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port data/instruction memory between two requesters: the instruction fetch port (IF) and the load/store unit (LSU).
- Issues at most one memory access per cycle and tags each read with its owner.
- Returns each read result to the correct requester after the memory's fixed read latency.
- Holds the last returned data per requester, so a stalled pipeline stage sees stable data.

Parameters:
- AW, 32, address width in bits
- DW, 32, data width in bits; must be a multiple of 8
- RD_LAT, 1, memory read latency in cycles; legal values 1..4
- MAX_STARVE, 4, consecutive IF denials before IF is forced to win (used only with the optional feature)

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset
- i_if_req  in  1  IF read request
- i_if_addr  in  AW  IF read address
- o_if_gnt  out  1  IF request accepted this cycle
- o_if_rvalid  out  1  IF read data valid (one cycle)
- o_if_rdata  out  DW  IF read data (held)
- i_ls_req  in  1  LSU request
- i_ls_we  in  1  LSU write enable
- i_ls_addr  in  AW  LSU address
- i_ls_wdata  in  DW  LSU write data
- i_ls_bmask  in  DW/8  LSU byte mask
- o_ls_gnt  out  1  LSU request accepted
- o_ls_rvalid  out  1  LSU read data valid (one cycle)
- o_ls_rdata  out  DW  LSU read data (held)
- o_mem_en  out  1  memory access enable
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  AW  memory address
- o_mem_wdata  out  DW  memory write data
- o_mem_bmask  out  DW/8  memory byte mask
- i_mem_rdata  in  DW  memory read data, valid RD_LAT cycles after a read

Behaviour:
- Reset: i_reset is asynchronous, active-high; clock is i_clk.
  - During reset, all outputs are 0, the tag pipeline is cleared, and the starve counter is 0.
- Arbitration:
  - Combinational grant in the same cycle as the request.
  - Requests are level-held by the requester until granted.
  - Default priority: LSU > IF.
  - Exactly one of o_if_gnt/o_ls_gnt is asserted when any request is present; neither when none.
- Memory drive:
  - o_mem_* are combinational from the winning request.
  - o_mem_we = i_ls_we only when the LSU wins; otherwise 0.
  - o_mem_bmask = all ones for IF.
  - When there is no grant: o_mem_en=0, o_mem_we=0, and the address/data outputs keep their last value (registered mux select).
- Tag pipeline (RD_LAT stages):
  - Each cycle, shift in {valid, owner}.
  - valid=1 only for a granted read; LSU writes insert valid=0.
  - Owner encoding: 0=IF, 1=LSU.
- Response:
  - When the tail stage is valid, assert the owner's rvalid for exactly one cycle.
  - Register i_mem_rdata into that owner's rdata holding register on the same edge. Both rdata outputs are driven from these registers.
  - The non-owner's rdata is unchanged.
  - Consequently, rvalid/rdata appear RD_LAT+1 cycles after the grant: one cycle memory, RD_LAT-1 additional pipeline stages, and one capture register.
  - Back-to-back reads from alternating owners return in issue order without bubbles.
- Simultaneous events:
  - A new grant and a response in the same cycle are independent.
  - Both requesters asserting every cycle results in IF starvation unless the optional feature is enabled.
- Reset mid-operation: in-flight reads are discarded; no rvalid follows reset deassertion.
- Illegal RD_LAT: elaboration error (generate-time check).

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN
- Enabled:
  - A 3-bit saturating starve counter increments on each cycle where IF requests and LSU wins.
  - The counter resets to 0 on any IF grant or when IF is not requesting.
  - When counter == MAX_STARVE, IF wins over LSU for that cycle; the LSU is not granted and must hold its request.
- Disabled:
  - The counter is absent and priority is strict LSU > IF.

Test Plan:
- Reset, then IF read addr 0x10 with memory returning 0xDEADBEEF (RD_LAT=1) -> o_if_gnt=1 in cycle 0; o_if_rvalid=1 with o_if_rdata=0xDEADBEEF two cycles after grant; o_ls_rvalid stays 0.
- IF and LSU read in the same cycle (LSU addr 0x20) -> o_ls_gnt=1, o_if_gnt=0, o_mem_addr=0x20. Next cycle IF is granted; responses arrive LSU first, then IF, on consecutive cycles.
- LSU write 0x12345678 with bmask 0x3 to 0x40 -> o_mem_we=1, o_mem_bmask=0x3; no o_ls_rvalid follows. A subsequent LSU read of 0x40 returns the stored value.
- RD_LAT=3 with alternating IF/LSU reads over 6 cycles -> each rvalid fires exactly 4 cycles after its grant to the correct owner; held rdata is unchanged on non-owner cycles.
- With MEM_ARB_STARVE_GUARD_EN and MAX_STARVE=4, both requesting continuously -> pattern is 4 LSU grants then 1 IF grant, repeating. Without the macro -> IF is never granted.
- Assert i_reset for 1 cycle while 2 reads are in flight -> all outputs read 0 and no rvalid appears afterwards.
